// File: rtl/qft_seq_engine_pkg.sv
// Shared constants and types for the sequential QFT engine.
// Coefficients are stored at 12 fractional bits and rescaled to the build's FRAC.
package qft_seq_engine_pkg;

  localparam int DW_DEF     = 16;
  localparam int FRAC_DEF   = 12;
  localparam int CONST_FRAC = 12;

  // round(2^12/sqrt2) and cos/sin of pi/2^m for m = 1..3
  localparam int K_C     = 2896;
  localparam int TW1_COS = 0;
  localparam int TW1_SIN = 4096;
  localparam int TW2_COS = 2896;
  localparam int TW2_SIN = 2896;
  localparam int TW3_COS = 3784;
  localparam int TW3_SIN = 1567;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HPASS,
    ST_CPASS,
    ST_UNLOAD
  } state_t;

  function automatic int scale_c(input int c, input int frac);
    if (frac >= CONST_FRAC) begin
      return c <<< (frac - CONST_FRAC);
    end
    return (c + (1 <<< (CONST_FRAC - frac - 1))) >>> (CONST_FRAC - frac);
  endfunction

endpackage

// File: rtl/qft_seq_engine_cplx_mul_rs.sv
// Combinational complex multiply: full-width product, round-half-up shift by FRAC, saturate to DW.
// Zero latency; no flow control.
module cplx_mul_rs
  import qft_seq_engine_pkg::*;
#(
  parameter int AW   = 17,
  parameter int CW   = 14,
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [AW-1:0] a_re,
  input  logic signed [AW-1:0] a_im,
  input  logic signed [CW-1:0] w_re,
  input  logic signed [CW-1:0] w_im,
  output logic signed [DW-1:0] p_re,
  output logic signed [DW-1:0] p_im,
  output logic                 sat
);

  localparam int PW = AW + CW + 1;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = PW'(-(1 <<< (DW - 1)));

  logic signed [PW-1:0] ar, ai, wr, wi;
  logic signed [PW-1:0] full_re, full_im, sh_re, sh_im;
  logic                 sat_re, sat_im;

  always_comb begin
    ar = PW'(a_re);
    ai = PW'(a_im);
    wr = PW'(w_re);
    wi = PW'(w_im);
    full_re = ar * wr - ai * wi;
    full_im = ar * wi + ai * wr;
    sh_re = (full_re + HALF) >>> FRAC;
    sh_im = (full_im + HALF) >>> FRAC;
    sat_re = (sh_re > MAXV) || (sh_re < MINV);
    sat_im = (sh_im > MAXV) || (sh_im < MINV);
    p_re = (sh_re > MAXV) ? DW'(MAXV) : (sh_re < MINV) ? DW'(MINV) : DW'(sh_re);
    p_im = (sh_im > MAXV) ? DW'(MAXV) : (sh_im < MINV) ? DW'(MINV) : DW'(sh_im);
    sat = sat_re | sat_im;
  end

endmodule

// File: rtl/qft_seq_engine.sv
// Sequential in-place QFT over an N=2^NQ register file: load N beats, Hadamard/phase passes, unload bit-reversed.
// Compute takes NQ*N/2 + NQ(NQ-1)/2*N cycles; in_ready only while loading, output holds under out_ready=0.
module qft_seq_engine
  import qft_seq_engine_pkg::*;
#(
  parameter int NQ   = 3,
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sat
);

  localparam int N  = 1 << NQ;
  localparam int AW = DW + 1;
  localparam int CW = FRAC + 2;
  localparam logic [NQ-1:0] LAST_PAIR = NQ'((1 << (NQ - 1)) - 1);
  localparam logic [NQ-1:0] LAST_IDX  = NQ'(N - 1);
  localparam logic signed [CW-1:0] K_W    = CW'(scale_c(K_C, FRAC));
  localparam logic signed [CW-1:0] T1_COS = CW'(scale_c(TW1_COS, FRAC));
  localparam logic signed [CW-1:0] T1_SIN = CW'(scale_c(TW1_SIN, FRAC));
  localparam logic signed [CW-1:0] T2_COS = CW'(scale_c(TW2_COS, FRAC));
  localparam logic signed [CW-1:0] T2_SIN = CW'(scale_c(TW2_SIN, FRAC));
  localparam logic signed [CW-1:0] T3_COS = CW'(scale_c(TW3_COS, FRAC));
  localparam logic signed [CW-1:0] T3_SIN = CW'(scale_c(TW3_SIN, FRAC));

  function automatic logic [NQ-1:0] bitrev(input logic [NQ-1:0] v);
    logic [NQ-1:0] r;
    for (int k = 0; k < NQ; k++) r[k] = v[NQ-1-k];
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [1:0]           t_q, t_d, c_q, c_d;
  logic [NQ-1:0]        cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 in_ready_q, in_ready_d, busy_q, busy_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [DW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [DW-1:0] mem_re_q [N];
  logic signed [DW-1:0] mem_im_q [N];
  logic signed [DW-1:0] mem_re_d [N];
  logic signed [DW-1:0] mem_im_d [N];

  logic [NQ-1:0]        lo_mask, idx_i, idx_j;
  logic signed [AW-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [AW-1:0] ma_in_re, ma_in_im;
  logic signed [CW-1:0] wa_re, wa_im, tw_re, tw_im;
  logic                 phase_hit;
  logic signed [DW-1:0] ma_re, ma_im, mb_re, mb_im;
  logic                 ma_sat, mb_sat;

  // Operand selection: HPASS scales (a+b) and (a-b) by K, CPASS rotates mem[cnt] by the twiddle.
  always_comb begin
    lo_mask = (NQ'(1) << t_q) - NQ'(1);
    idx_i   = ((cnt_q & ~lo_mask) << 1) | (cnt_q & lo_mask);
    idx_j   = idx_i | (NQ'(1) << t_q);
    // DW+1 holds any DW-bit sum exactly, so the pre-scale clamp never engages
    sum_re  = AW'(mem_re_q[idx_i]) + AW'(mem_re_q[idx_j]);
    sum_im  = AW'(mem_im_q[idx_i]) + AW'(mem_im_q[idx_j]);
    dif_re  = AW'(mem_re_q[idx_i]) - AW'(mem_re_q[idx_j]);
    dif_im  = AW'(mem_im_q[idx_i]) - AW'(mem_im_q[idx_j]);
    phase_hit = cnt_q[t_q] && cnt_q[c_q];
    case (t_q - c_q)
      2'd1:    begin tw_re = T1_COS; tw_im = T1_SIN; end
      2'd2:    begin tw_re = T2_COS; tw_im = T2_SIN; end
      default: begin tw_re = T3_COS; tw_im = T3_SIN; end
    endcase
    if (state_q == ST_CPASS) begin
      ma_in_re = AW'(mem_re_q[cnt_q]);
      ma_in_im = AW'(mem_im_q[cnt_q]);
      wa_re    = tw_re;
      wa_im    = tw_im;
    end else begin
      ma_in_re = sum_re;
      ma_in_im = sum_im;
      wa_re    = K_W;
      wa_im    = '0;
    end
  end

  cplx_mul_rs #(.AW(AW), .CW(CW), .DW(DW), .FRAC(FRAC)) u_mul_a (
    .a_re(ma_in_re), .a_im(ma_in_im), .w_re(wa_re), .w_im(wa_im),
    .p_re(ma_re), .p_im(ma_im), .sat(ma_sat)
  );

  cplx_mul_rs #(.AW(AW), .CW(CW), .DW(DW), .FRAC(FRAC)) u_mul_b (
    .a_re(dif_re), .a_im(dif_im), .w_re(K_W), .w_im('0),
    .p_re(mb_re), .p_im(mb_im), .sat(mb_sat)
  );

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    mem_re_d = mem_re_q;
    mem_im_d = mem_im_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mem_re_d[0] = in_re;
          mem_im_d[0] = in_im;
          cnt_d       = NQ'(1);
          sat_d       = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          mem_re_d[cnt_q] = in_re;
          mem_im_d[cnt_q] = in_im;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            t_d     = 2'(NQ - 1);
            state_d = ST_HPASS;
          end else begin
            cnt_d = cnt_q + NQ'(1);
          end
        end
      end
      ST_HPASS: begin
        mem_re_d[idx_i] = ma_re;
        mem_im_d[idx_i] = ma_im;
        mem_re_d[idx_j] = mb_re;
        mem_im_d[idx_j] = mb_im;
        sat_d = sat_q | ma_sat | mb_sat;
        if (cnt_q == LAST_PAIR) begin
          cnt_d = '0;
          if (t_q == 2'd0) begin
            state_d = ST_UNLOAD;
          end else begin
            c_d     = t_q - 2'd1;
            state_d = ST_CPASS;
          end
        end else begin
          cnt_d = cnt_q + NQ'(1);
        end
      end
      ST_CPASS: begin
        if (phase_hit) begin
          mem_re_d[cnt_q] = ma_re;
          mem_im_d[cnt_q] = ma_im;
          sat_d = sat_q | ma_sat;
        end
        if (cnt_q == LAST_IDX) begin
          cnt_d = '0;
          if (c_q == 2'd0) begin
            t_d     = t_q - 2'd1;
            state_d = ST_HPASS;
          end else begin
            c_d = c_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + NQ'(1);
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + NQ'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output registers look at next-cycle memory so UNLOAD presents beat 0 on entry.
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_UNLOAD) begin
      out_valid_d = 1'b1;
      out_re_d    = mem_re_d[bitrev(cnt_d)];
      out_im_d    = mem_im_d[bitrev(cnt_d)];
      out_last_d  = (cnt_d == LAST_IDX);
    end else begin
      out_valid_d = 1'b0;
      out_re_d    = '0;
      out_im_d    = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_re_q <= mem_re_d;
    mem_im_q <= mem_im_d;
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_qft_seq_engine.sv
// Scoreboard bench: DUT 0 is the NQ=3 build, DUT 1 the NQ=2 build; a negedge monitor pops expected beats.
module tb_qft_seq_engine;

  typedef struct {
    int dut;
    int re;
    int im;
    bit last;
    int tol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid [2];
  logic in_ready [2];
  logic signed [15:0] in_re, in_im;
  logic out_valid [2];
  logic out_ready;
  logic signed [15:0] out_re [2];
  logic signed [15:0] out_im [2];
  logic out_last [2];
  logic busy [2];
  logic sat [2];

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc [2] = '{0, 0};
  int exp_lat [2] = '{36, 8};
  bit rand_rdy = 1'b0;
  bit prev_vld [2] = '{1'b0, 1'b0};
  bit prev_stall [2] = '{1'b0, 1'b0};
  bit chk_rdy [2] = '{1'b0, 1'b0};
  int prev_re [2];
  int prev_im [2];
  int prev_last [2];

  int e1_re [8] = '{1448, 1024, 0, -1024, -1448, -1024, 0, 1024};
  int e1_im [8] = '{0, 1024, 1448, 1024, 0, -1024, -1448, -1024};
  int e2_re [4] = '{2048, 0, -2048, 0};
  int e2_im [4] = '{0, 2048, 0, -2048};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qft_seq_engine #(.NQ(3), .DW(16), .FRAC(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_re(out_re[0]), .out_im(out_im[0]), .out_last(out_last[0]),
    .busy(busy[0]), .sat(sat[0])
  );

  qft_seq_engine #(.NQ(2), .DW(16), .FRAC(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_re(out_re[1]), .out_im(out_im[1]), .out_last(out_last[1]),
    .busy(busy[1]), .sat(sat[1])
  );

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d t=%0t", name, act, exp, tol, $time);
    end
  endtask

  task automatic push_exp(input int d, input int re, input int im, input bit last, input int tol);
    exp_t e;
    e.dut = d; e.re = re; e.im = im; e.last = last; e.tol = tol;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input int d, input int re, input bit last);
    int w = 0;
    in_valid[d] = 1'b1;
    in_re = 16'(re);
    in_im = 16'sd0;
    while (!in_ready[d] && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) chk("in_ready_timeout", 0, 1, 0);
    if (last) last_cyc[d] = cyc + 1;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int n, input int idx, input int amp,
                            input bit all, input bit chk_clr);
    for (int k = 0; k < n; k++) begin
      send_beat(d, (all || k == idx) ? amp : 0, k == n - 1);
      if (chk_clr && k == 0) chk("sat_cleared", int'(sat[d]), 0, 0);
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid[0] || out_valid[1]) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("drain_timeout", exp_q.size(), 0, 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (out_valid[d] && !prev_vld[d]) chk("compute_latency", cyc - last_cyc[d], exp_lat[d], 0);
      if (prev_stall[d] && out_valid[d]) begin
        chk("hold_re", int'(out_re[d]), prev_re[d], 0);
        chk("hold_im", int'(out_im[d]), prev_im[d], 0);
        chk("hold_last", int'(out_last[d]), prev_last[d], 0);
      end
      if (chk_rdy[d]) begin
        chk("in_ready_after_last", int'(in_ready[d]), 1, 0);
        chk_rdy[d] = 1'b0;
      end
      if (out_valid[d]) chk("in_ready_low_unload", int'(in_ready[d]), 0, 0);
      if (out_valid[d] && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", d, -1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("beat_dut", d, e.dut, 0);
          chk("out_re", int'(out_re[d]), e.re, e.tol);
          chk("out_im", int'(out_im[d]), e.im, e.tol);
          chk("out_last", int'(out_last[d]), int'(e.last), 0);
          if (out_last[d]) chk_rdy[d] = 1'b1;
        end
      end
      prev_stall[d] = out_valid[d] && !out_ready;
      prev_vld[d]   = out_valid[d];
      prev_re[d]    = int'(out_re[d]);
      prev_im[d]    = int'(out_im[d]);
      prev_last[d]  = int'(out_last[d]);
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_re = '0;
    in_im = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", int'(in_ready[d]), 1, 0);
      chk("rst_out_valid", int'(out_valid[d]), 0, 0);
      chk("rst_out_re", int'(out_re[d]), 0, 0);
      chk("rst_out_im", int'(out_im[d]), 0, 0);
      chk("rst_out_last", int'(out_last[d]), 0, 0);
      chk("rst_busy", int'(busy[d]), 0, 0);
      chk("rst_sat", int'(sat[d]), 0, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // |000> -> flat 1448
    for (int k = 0; k < 8; k++) push_exp(0, 1448, 0, k == 7, 3);
    send_frame(0, 8, 0, 4096, 1'b0, 1'b0);
    wait_drain();

    // |001> -> 1448 * e^{i*2*pi*k/8}
    for (int k = 0; k < 8; k++) push_exp(0, e1_re[k], e1_im[k], k == 7, 3);
    send_frame(0, 8, 1, 4096, 1'b0, 1'b0);
    wait_drain();

    // same frame under random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(0, e1_re[k], e1_im[k], k == 7, 3);
    send_frame(0, 8, 1, 4096, 1'b0, 1'b0);
    wait_drain();
    rand_rdy = 1'b0;

    // full-scale input saturates into bin 0
    push_exp(0, 32767, 0, 1'b0, 0);
    for (int k = 1; k < 8; k++) push_exp(0, 0, 0, k == 7, 3);
    send_frame(0, 8, 0, 32767, 1'b1, 1'b0);
    wait_drain();
    chk("sat_set", int'(sat[0]), 1, 0);

    for (int k = 0; k < 8; k++) push_exp(0, 1448, 0, k == 7, 3);
    send_frame(0, 8, 0, 4096, 1'b0, 1'b1);
    wait_drain();
    chk("sat_clean_frame", int'(sat[0]), 0, 0);

    // abort a frame during CPASS
    send_frame(0, 8, 1, 4096, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("busy_mid_cpass", int'(busy[0]), 1, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", int'(busy[0]), 0, 0);
    chk("abort_out_valid", int'(out_valid[0]), 0, 0);
    chk("abort_in_ready", int'(in_ready[0]), 1, 0);
    for (int k = 0; k < 8; k++) push_exp(0, 1448, 0, k == 7, 3);
    send_frame(0, 8, 0, 4096, 1'b0, 1'b0);
    wait_drain();

    // NQ=2 build: |01> -> 2048 * {1, i, -1, -i}
    for (int k = 0; k < 4; k++) push_exp(1, e2_re[k], e2_im[k], k == 3, 3);
    send_frame(1, 4, 1, 4096, 1'b0, 1'b0);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
